gf_stage_seq: RTL and testbench
===============================

GF_STAGE_SEQ -- requirements
Module: gf_stage_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6, number of filter stages sequenced in index order 0..NUM_STAGES-1.
REQ-002 SHALL have parameter TIMEOUT, default 65536, maximum WAIT cycles per stage before abort.
REQ-003 SHALL have parameters ADDR_W, default 16, and DATA_W, default 24, the shared-RAM address and data widths.
REQ-004 iCLK  in  1  single clock; all state updates on rising edge.
REQ-005 iRST_N  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle request to process one frame.
REQ-007 stage_ena  out  NUM_STAGES  one-hot, one-cycle launch pulse to stage k.
REQ-008 stage_done  in  NUM_STAGES  done pulse from stage k.
REQ-009 s_wrenA, s_wrenB  in  NUM_STAGES  per-stage RAM write enables.
REQ-010 s_iAddrA, s_iAddrB  in  ADDR_W*NUM_STAGES  per-stage addresses, stage k in slice k.
REQ-011 s_iDataB  in  DATA_W*NUM_STAGES  per-stage write data, stage k in slice k.
REQ-012 wrenA, wrenB, iAddrA, iAddrB, iDataB  out  1/1/ADDR_W/ADDR_W/DATA_W  shared RAM port.
REQ-013 busy  out  1  high from LAUNCH of stage 0 until DONE/ERR exit.
REQ-014 frame_done  out  1  one-cycle pulse when the last stage completes.
REQ-015 err  out  1  sticky timeout flag.
REQ-016 cur_stage  out  $clog2(NUM_STAGES)  index of granted stage.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT, NEXT, DONE, ERR.
REQ-018 IDLE: start=1 -> LAUNCH, cur_stage<=0, err<=0; else stay.
REQ-019 LAUNCH: stage_ena[cur_stage]=1 for exactly this cycle; timer<=0; -> WAIT.
REQ-020 WAIT: stage_done[cur_stage]=1 -> DONE if cur_stage==NUM_STAGES-1, else NEXT; else timer+1.
REQ-021 WAIT with timer==TIMEOUT-1 and no done SHALL go to ERR; done in that same cycle wins.
REQ-022 NEXT: cur_stage+1 -> LAUNCH; stage_ena[k+1] rises exactly 2 cycles after the stage_done[k] cycle.
REQ-023 DONE: frame_done=1 one cycle -> IDLE; ERR: err<=1 -> IDLE.
REQ-024 Latency: start sampled at cycle t -> stage_ena[0] high at cycle t+1.
REQ-025 start while not IDLE SHALL be ignored, not queued.
REQ-026 stage_done bits of non-granted stages SHALL be ignored in all states.
REQ-027 In LAUNCH/WAIT the shared port SHALL carry slice cur_stage of every s_* input combinationally.
REQ-028 In all other states wrenA=wrenB=0, iAddrA=iAddrB=0, iDataB=0.
REQ-029 Timer SHALL be $clog2(TIMEOUT)+1 bits and never wrap.
REQ-030 busy = state in {LAUNCH, WAIT, NEXT}; stage_ena=0 outside LAUNCH.

Reset
REQ-031 iRST_N low SHALL force IDLE, cur_stage=0, timer=0, err=0 immediately, including mid-frame.
REQ-032 During and after reset: stage_ena=0, busy=0, frame_done=0, shared port all zero.

Structure
REQ-033 Shared package gf_pkg SHALL hold the state enum, IMG_W=300, IMG_H=210, PIX_CNT=63000, ADDR_W, DATA_W.
REQ-034 RAM port multiplexer SHALL be one sub-module gf_bus_mux (select, enable, flattened inputs, shared port outputs).

Verification
REQ-035 NUM_STAGES=6, start at cycle 10, each stage done 5 cycles after its ena -> stage_ena one-hot sequence 0..5, frame_done once, busy then 0.
REQ-036 stage_done[3] pulsed while stage 1 granted -> ignored; sequencing unchanged.
REQ-037 TIMEOUT=16, stage 2 never done -> ERR after 16 WAIT cycles, err=1, busy=0; next start clears err.
REQ-038 Stage 0 drives wrenB=1, addr=0x1234, data=0xABCDEF; stage 1 drives other values -> port shows stage 0 values only while stage 0 granted, zeros in NEXT.
REQ-039 iRST_N low during stage 3 WAIT -> IDLE, all outputs zero; new start restarts at stage 0.
REQ-040 start pulsed again mid-frame -> no effect; exactly one frame_done.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared definitions for the guided-filter stage sequencer: image geometry,
// shared-RAM port widths and the sequencer state encoding.
package gf_pkg;

  localparam int IMG_W   = 300;
  localparam int IMG_H   = 210;
  localparam int PIX_CNT = IMG_W * IMG_H;  // 63000 pixels per frame

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } gf_state_e;

endpackage

// File: rtl/gf_bus_mux.sv
// Shared RAM port multiplexer: while enabled, forwards the selected stage's
// slice of the flattened per-stage buses; otherwise drives an all-zero port.
module gf_bus_mux #(
  parameter int N      = 6,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int SEL_W  = 3
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  input  logic [N-1:0]        s_wrenA,
  input  logic [N-1:0]        s_wrenB,
  input  logic [ADDR_W*N-1:0] s_iAddrA,
  input  logic [ADDR_W*N-1:0] s_iAddrB,
  input  logic [DATA_W*N-1:0] s_iDataB,
  output logic                wrenA,
  output logic                wrenB,
  output logic [ADDR_W-1:0]   iAddrA,
  output logic [ADDR_W-1:0]   iAddrB,
  output logic [DATA_W-1:0]   iDataB
);
  import gf_pkg::*;

  // Select one stage slice; an out-of-range select leaves the port at zero.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    wrenA  = 1'b0;
    wrenB  = 1'b0;
    iAddrA = '0;
    iAddrB = '0;
    iDataB = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (sel == SEL_W'(k)) begin
          wrenA  = s_wrenA[k];
          wrenB  = s_wrenB[k];
          iAddrA = s_iAddrA[k*ADDR_W +: ADDR_W];
          iAddrB = s_iAddrB[k*ADDR_W +: ADDR_W];
          iDataB = s_iDataB[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/gf_stage_seq.sv
// Guided-filter stage sequencer: launches stages 0..NUM_STAGES-1 one at a
// time, grants the shared RAM port to the active stage, and aborts a frame
// with a sticky error when a stage exceeds its done timeout.
module gf_stage_seq #(
  parameter  int NUM_STAGES = 6,
  parameter  int TIMEOUT    = 65536,
  parameter  int ADDR_W     = gf_pkg::ADDR_W,
  parameter  int DATA_W     = gf_pkg::DATA_W,
  localparam int SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         start,
  output logic [NUM_STAGES-1:0]        stage_ena,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES-1:0]        s_wrenA,
  input  logic [NUM_STAGES-1:0]        s_wrenB,
  input  logic [ADDR_W*NUM_STAGES-1:0] s_iAddrA,
  input  logic [ADDR_W*NUM_STAGES-1:0] s_iAddrB,
  input  logic [DATA_W*NUM_STAGES-1:0] s_iDataB,
  output logic                         wrenA,
  output logic                         wrenB,
  output logic [ADDR_W-1:0]            iAddrA,
  output logic [ADDR_W-1:0]            iAddrB,
  output logic [DATA_W-1:0]            iDataB,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err,
  output logic [SEL_W-1:0]             cur_stage
);
  import gf_pkg::*;

  // One spare bit so the wait timer can never wrap back to zero.
  localparam int                TMR_W      = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0]  LAST_STAGE = SEL_W'(NUM_STAGES - 1);

  gf_state_e        state_q, state_d;
  logic [SEL_W-1:0] stage_q, stage_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q,   err_d;
  logic             done_sel;
  logic             port_en;

  // Done bit of the granted stage only; other stages' done pulses are ignored.
  always_comb begin
    done_sel = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_q == SEL_W'(k)) done_sel = stage_done[k];
    end
  end

  // Next-state logic plus the per-state launch and frame-done pulses.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    timer_d    = timer_q;
    err_d      = err_q;
    stage_ena  = '0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LAUNCH;
          stage_d = '0;
          err_d   = 1'b0;
        end
      end
      LAUNCH: begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          stage_ena[k] = (stage_q == SEL_W'(k));
        end
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving in the final timeout cycle still counts as success.
        if (done_sel) begin
          state_d = (stage_q == LAST_STAGE) ? DONE : NEXT;
        end else if (timer_q == TMR_LAST) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      NEXT: begin
        stage_d = stage_q + SEL_W'(1);
        state_d = LAUNCH;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, stage index, timer and sticky error; reset aborts any frame at once.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and the update order does not matter.
    if (!iRST_N) begin
      state_q <= IDLE;
      stage_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == NEXT);
  assign port_en   = (state_q == LAUNCH) || (state_q == WAIT);
  assign err       = err_q;
  assign cur_stage = stage_q;

  gf_bus_mux #(
    .N      (NUM_STAGES),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_bus_mux (
    .sel      (stage_q),
    .en       (port_en),
    .s_wrenA  (s_wrenA),
    .s_wrenB  (s_wrenB),
    .s_iAddrA (s_iAddrA),
    .s_iAddrB (s_iAddrB),
    .s_iDataB (s_iDataB),
    .wrenA    (wrenA),
    .wrenB    (wrenB),
    .iAddrA   (iAddrA),
    .iAddrB   (iAddrB),
    .iDataB   (iDataB)
  );

endmodule

// File: tb/tb_gf_stage_seq.sv
// Self-checking bench for gf_stage_seq: a behavioural frame model is compared
// against every DUT output on every cycle, plus literal timing expectations
// for directed scenarios, followed by a randomized soak.
module tb_gf_stage_seq;

  localparam int N  = 6;
  localparam int TO = 16;
  localparam int AW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  stage_ena, stage_done;
  logic [N-1:0]  s_wrenA, s_wrenB;
  logic [AW*N-1:0] s_iAddrA, s_iAddrB;
  logic [DW*N-1:0] s_iDataB;
  logic          wrenA, wrenB;
  logic [AW-1:0] iAddrA, iAddrB;
  logic [DW-1:0] iDataB;
  logic          busy, frame_done, err;
  logic [2:0]    cur_stage;

  gf_stage_seq #(.NUM_STAGES(N), .TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .start(start),
    .stage_ena(stage_ena), .stage_done(stage_done),
    .s_wrenA(s_wrenA), .s_wrenB(s_wrenB),
    .s_iAddrA(s_iAddrA), .s_iAddrB(s_iAddrB), .s_iDataB(s_iDataB),
    .wrenA(wrenA), .wrenB(wrenB), .iAddrA(iAddrA), .iAddrB(iAddrB), .iDataB(iDataB),
    .busy(busy), .frame_done(frame_done), .err(err), .cur_stage(cur_stage)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- stage responder ----------------
  int          dly [N];        // done arrives dly cycles after launch; <=0 never
  int          ena_cycle [N];  // cycle of most recent launch of each stage
  logic [N-1:0] extra_done;    // one-shot extra done bits for the next cycle
  bit          bus_rand;

  task automatic tick(input logic st);
    logic [N-1:0] d;
    @(posedge clk);
    #1;
    start = st;
    d = '0;
    for (int k = 0; k < N; k++)
      if (dly[k] > 0 && (cyc - ena_cycle[k]) == dly[k]) d[k] = 1'b1;
    stage_done = d | extra_done;
    extra_done = '0;
    if (bus_rand) begin
      for (int k = 0; k < N; k++) begin
        s_wrenA[k] = 1'($urandom);
        s_wrenB[k] = 1'($urandom);
        s_iAddrA[k*AW +: AW] = AW'($urandom);
        s_iAddrB[k*AW +: AW] = AW'($urandom);
        s_iDataB[k*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick(1'b0);
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a walk over stages; each stage is launched for one cycle,
  // then waits for its own done or gives up after TO waiting cycles.
  bit m_launch, m_wait, m_gap, m_done, m_errx, m_err;
  int m_stage, m_tmr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_launch = 0; m_wait = 0; m_gap = 0; m_done = 0; m_errx = 0; m_err = 0;
      m_stage = 0; m_tmr = 0;
    end else if (m_launch) begin
      m_launch = 0; m_wait = 1; m_tmr = 0;
    end else if (m_wait) begin
      if (stage_done[m_stage]) begin
        m_wait = 0;
        if (m_stage == N - 1) m_done = 1; else m_gap = 1;
      end else if (m_tmr == TO - 1) begin
        m_wait = 0; m_errx = 1;
      end else begin
        m_tmr++;
      end
    end else if (m_gap) begin
      m_gap = 0; m_stage++; m_launch = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_errx) begin
      m_errx = 0; m_err = 1;
    end else if (start) begin
      m_stage = 0; m_err = 0; m_launch = 1;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  logic [N-1:0]  e_ena;
  bit            e_grant;
  always @(negedge clk) begin
    e_ena   = m_launch ? N'(1 << m_stage) : '0;
    e_grant = m_launch || m_wait;
    check("stage_ena",  64'(stage_ena),  64'(e_ena));
    check("busy",       64'(busy),       64'(m_launch || m_wait || m_gap));
    check("frame_done", 64'(frame_done), 64'(m_done));
    check("err",        64'(err),        64'(m_err));
    check("cur_stage",  64'(cur_stage),  64'(m_stage));
    check("wrenA",  64'(wrenA),  e_grant ? 64'(s_wrenA[m_stage]) : 64'(0));
    check("wrenB",  64'(wrenB),  e_grant ? 64'(s_wrenB[m_stage]) : 64'(0));
    check("iAddrA", 64'(iAddrA), e_grant ? 64'(s_iAddrA[m_stage*AW +: AW]) : 64'(0));
    check("iAddrB", 64'(iAddrB), e_grant ? 64'(s_iAddrB[m_stage*AW +: AW]) : 64'(0));
    check("iDataB", 64'(iDataB), e_grant ? 64'(s_iDataB[m_stage*DW +: DW]) : 64'(0));
  end

  // ---------------- event log ----------------
  int ena_cyc_q[$];
  int ena_stg_q[$];
  int fd_q[$];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (stage_ena[k]) begin
        ena_cyc_q.push_back(cyc);
        ena_stg_q.push_back(k);
        ena_cycle[k] = cyc;
      end
    end
    if (frame_done) fd_q.push_back(cyc);
  end

  task automatic clear_log();
    ena_cyc_q.delete();
    ena_stg_q.delete();
    fd_q.delete();
  endtask

  // With every stage done 5 cycles after launch, stage k launches at
  // s+1+7k and the frame completes at s+42.
  task automatic check_frame(input int s);
    check("ena_count", 64'(ena_cyc_q.size()), 64'(N));
    for (int k = 0; k < N && k < ena_cyc_q.size(); k++) begin
      check("ena_cycle", 64'(ena_cyc_q[k]), 64'(s + 1 + 7*k));
      check("ena_stage", 64'(ena_stg_q[k]), 64'(k));
    end
    check("fd_count", 64'(fd_q.size()), 64'(1));
    if (fd_q.size() > 0) check("fd_cycle", 64'(fd_q[0]), 64'(s + 42));
  endtask

  // ---------------- stimulus ----------------
  int s;
  logic st;

  initial begin
    rst_n = 1'b0; start = 1'b0; stage_done = '0; extra_done = '0; bus_rand = 1'b0;
    s_wrenA = '0; s_wrenB = '0; s_iAddrA = '0; s_iAddrB = '0; s_iDataB = '0;
    for (int k = 0; k < N; k++) begin dly[k] = 5; ena_cycle[k] = -1000; end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ena",   64'(stage_ena), 64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_err",   64'(err),       64'(0));
    check("rst_stage", 64'(cur_stage), 64'(0));

    // Full frame, start at cycle 10.
    clear_log();
    run_to(9);
    tick(1'b1);
    s = cyc;
    check("start_cycle", 64'(s), 64'(10));
    run_to(s + 50);
    check_frame(s);
    check("idle_busy", 64'(busy), 64'(0));

    // Foreign done during stage 1 plus a second start mid-frame.
    clear_log();
    tick(1'b1);
    s = cyc;
    while (cyc < s + 50) begin
      if (cyc + 1 == s + 10) extra_done[3] = 1'b1;
      tick((cyc + 1 == s + 20) ? 1'b1 : 1'b0);
    end
    check_frame(s);

    // Shared port carries only the granted stage's values.
    s_wrenA[0] = 1'b0; s_wrenB[0] = 1'b1;
    s_iAddrA[0 +: AW] = 16'h0042; s_iAddrB[0 +: AW] = 16'h1234; s_iDataB[0 +: DW] = 24'hABCDEF;
    s_wrenA[1] = 1'b1; s_wrenB[1] = 1'b0;
    s_iAddrA[AW +: AW] = 16'h0777; s_iAddrB[AW +: AW] = 16'h5678; s_iDataB[DW +: DW] = 24'h123456;
    clear_log();
    tick(1'b1);
    s = cyc;
    tick(1'b0);
    @(negedge clk);
    check("p0_wrenB", 64'(wrenB),  64'(1));
    check("p0_addrB", 64'(iAddrB), 64'h1234);
    check("p0_dataB", 64'(iDataB), 64'hABCDEF);
    check("p0_addrA", 64'(iAddrA), 64'h0042);
    run_to(s + 3);
    @(negedge clk);
    check("p0w_dataB", 64'(iDataB), 64'hABCDEF);
    run_to(s + 7);
    @(negedge clk);
    check("next_busy", 64'(busy),   64'(1));
    check("next_port", {wrenA, wrenB, iAddrA, iAddrB, iDataB}, 64'(0));
    tick(1'b0);
    @(negedge clk);
    check("p1_wrenA", 64'(wrenA),  64'(1));
    check("p1_addrB", 64'(iAddrB), 64'h5678);
    check("p1_dataB", 64'(iDataB), 64'h123456);
    run_to(s + 50);
    check_frame(s);

    // Stage 2 never completes: timeout after 16 waiting cycles.
    dly[2] = -1;
    clear_log();
    tick(1'b1);
    s = cyc;
    run_to(s + 31);
    @(negedge clk);
    check("to_busy_hi", 64'(busy),      64'(1));
    check("to_stage",   64'(cur_stage), 64'(2));
    check("to_err_lo",  64'(err),       64'(0));
    tick(1'b0);
    @(negedge clk);
    check("to_busy_lo", 64'(busy), 64'(0));
    tick(1'b0);
    @(negedge clk);
    check("to_err_hi",  64'(err), 64'(1));
    check("to_ena_cnt", 64'(ena_cyc_q.size()), 64'(3));
    check("to_fd_cnt",  64'(fd_q.size()),      64'(0));
    run_to(s + 40);
    dly[2] = 5;
    tick(1'b1);
    @(negedge clk);
    check("restart_err_held", 64'(err), 64'(1));
    tick(1'b0);
    @(negedge clk);
    check("restart_err_clr", 64'(err),       64'(0));
    check("restart_ena0",    64'(stage_ena), 64'(1));
    run_to(cyc + 50);

    // Reset during stage 3 wait, then a clean frame.
    clear_log();
    tick(1'b1);
    s = cyc;
    run_to(s + 24);
    check("pre_rst_stage", 64'(cur_stage), 64'(3));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ena",   64'(stage_ena),  64'(0));
    check("mid_rst_busy",  64'(busy),       64'(0));
    check("mid_rst_stage", 64'(cur_stage),  64'(0));
    check("mid_rst_port",  {wrenA, wrenB, iAddrA, iAddrB, iDataB}, 64'(0));
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
    clear_log();
    tick(1'b1);
    s = cyc;
    run_to(s + 50);
    check_frame(s);

    // Randomized soak against the model.
    bus_rand = 1'b1;
    repeat (3000) begin
      st = ($urandom_range(0, 9) == 0);
      if (st) for (int k = 0; k < N; k++) dly[k] = int'($urandom_range(1, 18));
      if ($urandom_range(0, 15) == 0) extra_done = N'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0;
        tick(1'b0);
        rst_n = 1'b1;
      end
      tick(st);
    end
    tick(1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
